// File: rtl/bist_ctrl.sv
// bist_ctrl: logic-BIST sequencer (seed, run, flush, capture, golden compare).
// Optional mid-run signature check enabled by defining BIST_MIDCHECK_EN.
module bist_ctrl #(
  parameter int SIG_W = 8,
  parameter int NUM_PATTERNS = 255,
  parameter int PIPE_LAT = 2,
  parameter logic [SIG_W-1:0] GOLDEN = '0,
  parameter logic [SIG_W-1:0] MID_GOLDEN = '0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Abort,
  input  logic [SIG_W-1:0] Signature,
  output logic             Set_out,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [SIG_W-1:0] Sig_cap
`ifdef BIST_MIDCHECK_EN
  ,
  output logic             Mid_fail
`endif
);
  localparam int CW = $clog2(NUM_PATTERNS + 1) < 4 ? 4 : $clog2(NUM_PATTERNS + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS - 1);
  localparam logic [CW-1:0] MID = CW'(NUM_PATTERNS / 2);
  localparam logic [CW-1:0] FL_LAST = CW'(PIPE_LAT - 1);
  typedef enum logic [2:0] {IDLE, SEED, RUN, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d, pass_q, pass_d, set_q, set_d, busy_q, busy_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic mid_ok;
`ifdef BIST_MIDCHECK_EN
  logic mid_q, mid_d;
  assign mid_ok = ~mid_q;
  assign Mid_fail = mid_q;
`else
  assign mid_ok = 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    done_d = done_q;
    pass_d = pass_q;
    sig_d = sig_q;
`ifdef BIST_MIDCHECK_EN
    mid_d = mid_q;
`endif
    if (Abort) begin
      state_d = IDLE;
      cnt_d = '0;
      done_d = 1'b0;
      pass_d = 1'b0;
`ifdef BIST_MIDCHECK_EN
      mid_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: if (Start) begin
          state_d = SEED;
          cnt_d = '0;
          done_d = 1'b0;
          pass_d = 1'b0;
`ifdef BIST_MIDCHECK_EN
          mid_d = 1'b0;
`endif
        end
        SEED: begin
          state_d = RUN;
          cnt_d = '0;
        end
        RUN: begin
          state_d = cnt_q == LAST ? FLUSH : RUN;
          cnt_d = cnt_q == LAST ? '0 : cnt_q + CW'(1);
`ifdef BIST_MIDCHECK_EN
          if (cnt_q == MID && Signature != MID_GOLDEN) mid_d = 1'b1;
`endif
        end
        FLUSH: if (cnt_q == FL_LAST) begin
          state_d = DONE;
          cnt_d = '0;
          sig_d = Signature;
          pass_d = (Signature == GOLDEN) & mid_ok;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
    // Strobes follow the next state so they stay registered with no input path
    set_d = state_d == IDLE || state_d == SEED || state_d == DONE;
    busy_d = state_d == SEED || state_d == RUN || state_d == FLUSH;
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      sig_q <= '0;
      set_q <= 1'b1;
      busy_q <= 1'b0;
`ifdef BIST_MIDCHECK_EN
      mid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      pass_q <= pass_d;
      sig_q <= sig_d;
      set_q <= set_d;
      busy_q <= busy_d;
`ifdef BIST_MIDCHECK_EN
      mid_q <= mid_d;
`endif
    end
  end
  assign Set_out = set_q;
  assign Busy = busy_q;
  assign Done = done_q;
  assign Pass = pass_q;
  assign Sig_cap = sig_q;
  logic unused_mid;
  assign unused_mid = ^MID;
endmodule

// File: tb/tb_bist_ctrl.sv
// tb_bist_ctrl: directed and random checks of bist_ctrl against a latency-based run model.
module tb_bist_ctrl;
  localparam int NP = 15;
  localparam int PL = 2;
  localparam logic [7:0] GOLD = 8'hA5;
  localparam logic [7:0] MIDG = 8'h3C;
  localparam int RUN_LEN = 1 + NP + PL;
`ifdef BIST_MIDCHECK_EN
  localparam bit MIDCHK = 1'b1;
`else
  localparam bit MIDCHK = 1'b0;
`endif
  logic Clk, Rst, Start, Abort;
  logic [7:0] Signature, Sig_cap;
  logic Set_out, Busy, Done, Pass, mid_fail_o;
  int checks = 0, errs = 0;
  int age = -1;
  bit m_done = 0, m_pass = 0, m_mid = 0;
  logic [7:0] m_sig = 8'h00;

  bist_ctrl #(.SIG_W(8), .NUM_PATTERNS(NP), .PIPE_LAT(PL), .GOLDEN(GOLD), .MID_GOLDEN(MIDG)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Abort(Abort), .Signature(Signature),
    .Set_out(Set_out), .Busy(Busy), .Done(Done), .Pass(Pass), .Sig_cap(Sig_cap)
`ifdef BIST_MIDCHECK_EN
    , .Mid_fail(mid_fail_o)
`endif
  );
`ifndef BIST_MIDCHECK_EN
  assign mid_fail_o = 1'b0;
`endif

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    bit run_phase;
    run_phase = age >= 0 && !m_done;
    chk({tag, ".set"}, {31'b0, Set_out}, {31'b0, !(run_phase && age >= 1)});
    chk({tag, ".busy"}, {31'b0, Busy}, {31'b0, run_phase});
    chk({tag, ".done"}, {31'b0, Done}, {31'b0, m_done});
    chk({tag, ".pass"}, {31'b0, Pass}, {31'b0, m_pass});
    chk({tag, ".sig"}, {24'b0, Sig_cap}, {24'b0, m_sig});
    if (MIDCHK) chk({tag, ".mid"}, {31'b0, mid_fail_o}, {31'b0, m_mid});
  endtask

  task automatic model_reset();
    age = -1; m_done = 0; m_pass = 0; m_mid = 0; m_sig = 8'h00;
  endtask

  // One clock: drive at negedge, update model at posedge, compare 1 time unit later
  task automatic cyc(input bit st, input bit ab, input logic [7:0] sg, input string tag);
    @(negedge Clk);
    Start = st; Abort = ab; Signature = sg;
    @(posedge Clk);
    if (ab) begin
      age = -1; m_done = 0; m_pass = 0; m_mid = 0;
    end else if ((age < 0 || m_done) && st) begin
      age = 0; m_done = 0; m_pass = 0; m_mid = 0;
    end else if (age >= 0 && !m_done) begin
      age++;
      if (MIDCHK && age == 2 + NP / 2 && sg != MIDG) m_mid = 1;
      if (age == RUN_LEN) begin
        m_done = 1; m_sig = sg; m_pass = (sg == GOLD) && !m_mid;
      end
    end
    #1 chk_all(tag);
  endtask

  // Start at index 0, then RUN_LEN more cycles; optional extra Start / Abort at given indices
  task automatic run(input logic [7:0] mid_sig, input logic [7:0] fin, input int st_at, input int ab_at, input string tag);
    cyc(1, 0, 8'h77, tag);
    for (int i = 1; i <= RUN_LEN; i++)
      cyc(i == st_at, i == ab_at, i == 2 + NP / 2 ? mid_sig : i == RUN_LEN ? fin : 8'($urandom), tag);
  endtask

  initial begin
    Rst = 1; Start = 0; Abort = 0; Signature = 8'h00;
    repeat (2) @(negedge Clk);
    #1 chk_all("reset");
    @(negedge Clk) Rst = 0;
    cyc(0, 0, 8'h11, "idle");
    run(MIDG, GOLD, -1, -1, "pass_run");
    chk("pass_run.final_pass", {31'b0, Pass}, 32'd1);
    chk("pass_run.final_sig", {24'b0, Sig_cap}, 32'hA5);
    repeat (3) cyc(0, 0, 8'($urandom), "done_hold");
    run(MIDG, 8'h5A, -1, -1, "fail_run");
    chk("fail_run.final_pass", {31'b0, Pass}, 32'd0);
    chk("fail_run.final_sig", {24'b0, Sig_cap}, 32'h5A);
    run(MIDG, GOLD, 7, -1, "start_ignored");
    chk("start_ignored.done", {31'b0, Done}, 32'd1);
    run(MIDG, GOLD, -1, 9, "abort_run");
    chk("abort_run.done", {31'b0, Done}, 32'd0);
    chk("abort_run.busy", {31'b0, Busy}, 32'd0);
    run(MIDG, GOLD, -1, -1, "after_abort");
    run(8'h00, GOLD, -1, -1, "mid_run");
    chk("mid_run.pass", {31'b0, Pass}, {31'b0, !MIDCHK});
    cyc(1, 0, 8'h00, "mid_clear");
    repeat (6) cyc(0, 0, 8'($urandom), "mid_clear");
    @(posedge Clk);
    #2 Rst = 1;
    #1 model_reset();
    chk_all("async_rst");
    @(negedge Clk) Rst = 0;
    cyc(1, 1, GOLD, "abort_vs_start");
    for (int n = 0; n < 800; n++) begin
      int r;
      r = $urandom_range(0, 3);
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 79) == 0,
          r < 2 ? GOLD : r == 2 ? MIDG : 8'($urandom), "random");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule

// File: doc/bist_ctrl.md
Name: bist_ctrl

Overview:
Logic-BIST sequencer that sits directly downstream of the MISR response analyzer, and beside the TPG LFSRs.
- Drives the shared Set line that seeds the TPGs and the MISR.
- Counts the test patterns, waits for the datapath and MISR pipeline to flush, then captures the MISR signature.
- Compares the captured signature against a golden value and reports done/pass to the test host.

Parameters:
SIG_W, 8, width of MISR signature.
NUM_PATTERNS, 255, patterns applied per run; legal range 1..65535.
PIPE_LAT, 2, flush cycles after the last pattern before the signature is stable; legal range 1..15.
GOLDEN, 8'h00, expected final signature; overridden per product.
MID_GOLDEN, 8'h00, expected signature at pattern NUM_PATTERNS/2; used only with BIST_MIDCHECK_EN.

Ports:
Clk  input  1  system clock, rising edge.
Rst  input  1  asynchronous, active-high reset.
Start  input  1  begin a BIST run; sampled only in IDLE or DONE.
Abort  input  1  synchronous abort from any state.
Signature  input  SIG_W  MISR Q output.
Set_out  output  1  seed strobe to the TPG and MISR Set inputs.
Busy  output  1  high in SEED, RUN and FLUSH.
Done  output  1  run complete; result is valid.
Pass  output  1  1 when the captured signature matches; valid only while Done=1.
Sig_cap  output  SIG_W  captured final signature.
Mid_fail  output  1  sticky mid-run mismatch; present only with BIST_MIDCHECK_EN.

Behaviour:
- Reset (async, Rst=1):
  - state=IDLE; Set_out=1, so the TPGs and MISR are held seeded.
  - Busy=0, Done=0, Pass=0, Sig_cap=0, Mid_fail=0, counter=0.
- All outputs are registered; none has a combinational path from the inputs.
- States: IDLE, SEED, RUN, FLUSH, DONE.
- IDLE:
  - Set_out=1.
  - Start=1 at a rising edge -> SEED.
- SEED: exactly 1 cycle; Set_out=1, Busy=1; counter cleared -> RUN.
- RUN:
  - Set_out=0, Busy=1; counter increments once per cycle.
  - When counter==NUM_PATTERNS-1 at an edge -> FLUSH, counter cleared.
  - RUN lasts exactly NUM_PATTERNS cycles.
- FLUSH:
  - Lasts PIPE_LAT cycles; Set_out=0.
  - At the edge that ends the last FLUSH cycle: Sig_cap<=Signature, Pass<=(Signature==GOLDEN), Done<=1, Busy<=0 -> DONE.
- DONE:
  - Set_out=1, returning the datapath to the seed state; Done, Pass and Sig_cap are held.
  - Start=1 -> SEED; Done and Pass clear in the same edge.
- Latency: with Start sampled at edge E0, Done rises at edge E0+1+NUM_PATTERNS+PIPE_LAT.
- Start while Busy=1 is ignored.
- Abort=1 at any edge:
  - -> IDLE; Done=0, Pass=0, Sig_cap unchanged, counter cleared.
  - Abort has priority over Start in the same cycle.
- Counter width: ceil(log2(NUM_PATTERNS+1)), minimum 4 bits, so the FLUSH count also fits. No wrap-around is possible within legal parameter ranges.
- Rst asserted mid-run: immediate return to the reset values; no partial result is retained.

Optional Feature:
Macro BIST_MIDCHECK_EN.
- Defined:
  - At the edge where the RUN counter==NUM_PATTERNS/2 (integer division), Signature is compared against MID_GOLDEN.
  - A mismatch sets the Mid_fail port; Mid_fail is sticky until SEED, Abort or Rst.
  - Final Pass<=(Signature==GOLDEN) & ~Mid_fail.
- Not defined: the Mid_fail port and its logic are absent; Pass depends only on the final compare.

Test Plan:
1. Reset behaviour: Rst pulse mid-simulation, asynchronous to Clk -> outputs go to reset values immediately (Set_out=1, Busy=0, Done=0, Pass=0, Sig_cap=8'h00), without waiting for a Clk edge.
2. Passing run:
   - Setup: NUM_PATTERNS=15, PIPE_LAT=2, GOLDEN=8'hA5; bench drives Signature=8'hA5 from pattern 14 onward.
   - Stimulus: Start pulse at edge E0.
   - Required: Set_out=1 during SEED; Set_out=0 for 17 cycles; Done=1 at E0+18 with Pass=1 and Sig_cap=8'hA5; Set_out returns to 1.
3. Failing run: same setup as scenario 2 with Signature=8'h5A at capture -> Done=1 at E0+18, Pass=0, Sig_cap=8'h5A.
4. Start/Abort interaction:
   - Start pulse at RUN count 5 -> ignored; Done still rises at E0+18.
   - Separate run: Abort at RUN count 7 -> IDLE next edge, Busy=0, Done=0.
   - Next Start -> full 18-cycle run.
5. Restart from DONE: Start in DONE -> Done and Pass clear at the same edge, SEED entered; second result reported after another 18 cycles.
6. Mid-run check (BIST_MIDCHECK_EN, MID_GOLDEN=8'h3C):
   - Signature=8'h00 at count 7 -> Mid_fail=1.
   - Final Signature=GOLDEN anyway -> Pass=0.
   - Next Start clears Mid_fail.
